sar_search: RTL and testbench

//   Successive-approximation controller: the initiator side of a magnitude comparator.

---
 rtl/sar_search.sv | 115 +++++++++++
 tb/tb_sar_search.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/sar_search.sv
// Successive-approximation search controller: walks a trial code MSB-first against an
// external "trial <= reference" comparator and reports the largest code not above it.
module sar_search #(
  parameter int WIDTH  = 10,
  parameter int SETTLE = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             cmp_le,
  output logic [WIDTH-1:0] trial,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int IDXW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_TEST,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] code_q, code_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] bitMask;
  logic             sampleNow;

  assign bitMask   = {{(WIDTH-1){1'b0}}, 1'b1} << idx_q;
  assign sampleNow = (cnt_q == 4'(SETTLE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      code_q   <= '0;
      idx_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      code_q   <= code_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  // Abort wins over the final sample, so an aborted search never touches result.
  always_comb begin
    state_d  = state_q;
    code_d   = code_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          code_d  = '0;
          idx_d   = IDXW'(WIDTH - 1);
          cnt_d   = '0;
          state_d = S_TEST;
        end
      end
      S_TEST: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (sampleNow) begin
          cnt_d = '0;
          if (cmp_le) begin
            code_d = code_q | bitMask;
          end
          if (idx_q == '0) begin
            result_d = cmp_le ? (code_q | bitMask) : code_q;
            state_d  = S_DONE;
          end else begin
            idx_d = idx_q - IDXW'(1);
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    trial = '0;
    busy  = 1'b0;
    done  = 1'b0;
    case (state_q)
      S_TEST: begin
        trial = code_q | bitMask;
        busy  = 1'b1;
      end
      S_DONE: begin
        done = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign result = result_q;

endmodule

// File: tb/tb_sar_search.sv
// Scoreboard bench for sar_search: a SETTLE=0 and a SETTLE=3 instance, each driven
// against a model comparator with expected results queued at launch time.
module tb_sar_search;

  typedef struct {
    int res;
    int cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start0 = 1'b0, abort0 = 1'b0, cmp0;
  logic       start3 = 1'b0, abort3 = 1'b0, cmp3 = 1'b0;
  logic [9:0] trial0, result0, trial3, result3;
  logic       busy0, done0, busy3, done3;
  logic [9:0] ref0 = '0;
  int         cycleCnt = 0;
  int         total = 0;
  int         bad = 0;
  exp_t       q0[$];
  exp_t       q3[$];
  int         tq[$];

  always #5 clk = ~clk;
  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  assign cmp0 = (trial0 <= ref0);

  sar_search #(.WIDTH(10), .SETTLE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0), .cmp_le(cmp0),
    .trial(trial0), .busy(busy0), .done(done0), .result(result0)
  );

  sar_search #(.WIDTH(10), .SETTLE(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .abort(abort3), .cmp_le(cmp3),
    .trial(trial3), .busy(busy3), .done(done3), .result(result3)
  );

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cycleCnt);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Launch one SETTLE=0 search; start is high in the launch cycle only.
  task automatic applyStimulus(input int r);
    exp_t e;
    ref0   = 10'(r);
    start0 = 1'b1;
    e.res  = r;
    e.cyc  = cycleCnt + 11;
    q0.push_back(e);
    step();
    start0 = 1'b0;
    repeat (11) step();
  endtask

  // SETTLE=3 search; cmp3 is deliberately wrong on every non-sampling cycle.
  task automatic applySettle(input int r);
    exp_t e;
    start3 = 1'b1;
    e.res  = r;
    e.cyc  = cycleCnt + 41;
    q3.push_back(e);
    step();
    start3 = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      cmp3 = ((c % 4) == 0) ? (int'(trial3) <= r) : !(int'(trial3) <= r);
      step();
    end
    cmp3 = 1'b1;
    step();
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      logic exp0, exp3;
      exp0 = (q0.size() > 0) && (q0[0].cyc == cycleCnt);
      if (done0 || exp0) checkOutput("done0", int'(done0), int'(exp0));
      if (exp0) begin
        checkOutput("result0", int'(result0), q0[0].res);
        checkOutput("busy0_in_done", int'(busy0), 0);
        checkOutput("trial0_in_done", int'(trial0), 0);
        void'(q0.pop_front());
      end
      if (busy0 && tq.size() > 0) begin
        checkOutput("trial0_seq", int'(trial0), tq.pop_front());
      end
      exp3 = (q3.size() > 0) && (q3[0].cyc == cycleCnt);
      if (done3 || exp3) checkOutput("done3", int'(done3), int'(exp3));
      if (exp3) begin
        checkOutput("result3", int'(result3), q3[0].res);
        void'(q3.pop_front());
      end
    end
  end

  initial begin
    int seq[10];
    int launch;
    seq = '{512, 768, 640, 576, 544, 528, 520, 516, 514, 513};

    #2;
    checkOutput("reset_trial0", int'(trial0), 0);
    checkOutput("reset_busy0", int'(busy0), 0);
    checkOutput("reset_done0", int'(done0), 0);
    checkOutput("reset_result0", int'(result0), 0);
    checkOutput("reset_result3", int'(result3), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    step();

    foreach (seq[k]) tq.push_back(seq[k]);
    applyStimulus(512);
    checkOutput("trial_seq_consumed", tq.size(), 0);

    applyStimulus(0);
    applyStimulus(1023);
    applyStimulus(512);

    // Abort in cycle 5 of a ref=700 search
    ref0   = 10'd700;
    start0 = 1'b1;
    step();
    start0 = 1'b0;
    repeat (4) step();
    abort0 = 1'b1;
    start0 = 1'b1;
    step();
    abort0 = 1'b0;
    start0 = 1'b0;
    checkOutput("abort_busy", int'(busy0), 0);
    checkOutput("abort_done", int'(done0), 0);
    checkOutput("abort_result", int'(result0), 512);
    checkOutput("abort_trial", int'(trial0), 0);
    repeat (3) step();
    checkOutput("abort_result_hold", int'(result0), 512);
    applyStimulus(700);

    // start held high: three back-to-back searches, 12 cycles apart
    ref0   = 10'd333;
    start0 = 1'b1;
    launch = cycleCnt;
    for (int k = 0; k < 3; k++) q0.push_back('{333, launch + 11 + 12 * k});
    repeat (35) step();
    start0 = 1'b0;
    repeat (3) step();
    checkOutput("held_busy_after", int'(busy0), 0);

    applySettle(300);
    applySettle(1023);
    applySettle(0);

    // Async reset mid-search
    ref0   = 10'd100;
    start0 = 1'b1;
    step();
    start0 = 1'b0;
    repeat (3) step();
    checkOutput("pre_reset_busy", int'(busy0), 1);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("rst_trial0", int'(trial0), 0);
    checkOutput("rst_busy0", int'(busy0), 0);
    checkOutput("rst_done0", int'(done0), 0);
    checkOutput("rst_result0", int'(result0), 0);
    checkOutput("rst_result3", int'(result3), 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    applyStimulus(5);

    for (int r = 0; r < 1024; r++) applyStimulus(r);

    repeat (4) step();
    checkOutput("q0_drained", q0.size(), 0);
    checkOutput("q3_drained", q3.size(), 0);
    checkOutput("final_result0", int'(result0), 1023);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
